// File: rtl/cgra_pkg.sv
package cgra_pkg;

  localparam int unsigned N_COL             = 4;
  localparam int unsigned IMEM_N_LINES_LOG2 = 5;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN
  } launch_fsm_t;

endpackage

// File: rtl/cgra_col_group_tracker.sv
module cgra_col_group_tracker
  import cgra_pkg::*;
#(
  parameter int unsigned N_COL = cgra_pkg::N_COL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             launch_i,
  input  logic [N_COL-1:0] launch_mask_i,
  input  logic [N_COL-1:0] col_done_i,
  output logic [N_COL-1:0] acc_end_o,
  output logic [N_COL-1:0] busy_o,
  output logic             stray_done_o
);

  logic [N_COL-1:0] busy_q;
  logic [N_COL-1:0] done_q;
  logic [N_COL-1:0] eff_done;
  logic [N_COL-1:0] grp_q [N_COL];

  // A group ends in the same cycle as its last done pulse; ends of several groups are OR-ed.
  always_comb begin
    eff_done  = done_q | col_done_i;
    acc_end_o = '0;
    for (int unsigned c = 0; c < N_COL; c++) begin
      if (busy_q[c] && ((eff_done & grp_q[c]) == grp_q[c])) begin
        acc_end_o = acc_end_o | grp_q[c];
      end
    end
  end

  assign stray_done_o = |(col_done_i & ~busy_q);
  assign busy_o       = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      done_q <= '0;
      for (int unsigned c = 0; c < N_COL; c++) begin
        grp_q[c] <= '0;
      end
    end else begin
      busy_q <= (busy_q & ~acc_end_o) | (launch_i ? launch_mask_i : '0);
      done_q <= (done_q | (col_done_i & busy_q)) & ~acc_end_o;
      for (int unsigned c = 0; c < N_COL; c++) begin
        if (launch_i && launch_mask_i[c]) begin
          grp_q[c] <= launch_mask_i;
        end else if (acc_end_o[c]) begin
          grp_q[c] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/cgra_col_launcher.sv
module cgra_col_launcher
  import cgra_pkg::*;
#(
  parameter int unsigned N_COL    = cgra_pkg::N_COL,
  parameter int unsigned PC_WIDTH = cgra_pkg::IMEM_N_LINES_LOG2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_COL-1:0]    acc_req_i,
  input  logic [PC_WIDTH-1:0] pc_start_i,
  input  logic [N_COL-1:0]    col_done_i,
  output logic                acc_ack_o,
  output logic [N_COL-1:0]    col_start_o,
  output logic [PC_WIDTH-1:0] col_pc_o,
  output logic [N_COL-1:0]    acc_end_o,
  output logic [N_COL-1:0]    col_busy_o,
  output logic                err_o
);

  launch_fsm_t         state_q, state_d;
  logic [N_COL-1:0]    acc_req_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                err_q;
  logic                capture;
  logic                launch;
  logic                overlap_err;
  logic                stray_done;

  cgra_col_group_tracker #(
    .N_COL (N_COL)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .launch_i      (launch),
    .launch_mask_i (acc_req_q),
    .col_done_i    (col_done_i),
    .acc_end_o     (acc_end_o),
    .busy_o        (col_busy_o),
    .stray_done_o  (stray_done)
  );

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    launch      = 1'b0;
    overlap_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (|acc_req_i) begin
          if (~|(acc_req_i & col_busy_o)) begin
            state_d = LAUNCH;
            capture = 1'b1;
          end else begin
            overlap_err = 1'b1;
          end
        end
      end
      LAUNCH: begin
        launch  = 1'b1;
        state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_ack_o   = launch;
  assign col_start_o = launch ? acc_req_q : '0;
  assign col_pc_o    = launch ? pc_q : '0;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_req_q <= '0;
      pc_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        acc_req_q <= acc_req_i;
        pc_q      <= pc_start_i;
      end
      if (overlap_err || stray_done) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cgra_col_launcher.sv
module tb_cgra_col_launcher;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] acc_req_i;
  logic [4:0] pc_start_i;
  logic [3:0] col_done_i;
  logic       acc_ack_o;
  logic [3:0] col_start_o;
  logic [4:0] col_pc_o;
  logic [3:0] acc_end_o;
  logic [3:0] col_busy_o;
  logic       err_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state: which columns are owned, which have finished, who owns them
  logic [3:0]  m_busy;
  logic [3:0]  m_done;
  logic [3:0]  m_grp [4];
  logic        m_err;
  logic        m_launch;
  logic [3:0]  m_lmask;
  logic [4:0]  m_lpc;
  int unsigned m_ok_from;
  int unsigned cyc;

  cgra_col_launcher #(
    .N_COL    (4),
    .PC_WIDTH (5)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .acc_req_i   (acc_req_i),
    .pc_start_i  (pc_start_i),
    .col_done_i  (col_done_i),
    .acc_ack_o   (acc_ack_o),
    .col_start_o (col_start_o),
    .col_pc_o    (col_pc_o),
    .acc_end_o   (acc_end_o),
    .col_busy_o  (col_busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model past the edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic [4:0] pc, input logic [3:0] done);
    logic [3:0] e_end;
    logic [3:0] nb;
    logic [3:0] nd;
    @(negedge clk_i);
    rst_i      = rst;
    acc_req_i  = req;
    pc_start_i = pc;
    col_done_i = done;
    #1;
    e_end = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_busy[c] && (((m_done | done) & m_grp[c]) == m_grp[c])) e_end = e_end | m_grp[c];
    end
    check_val("ack",   32'(acc_ack_o),   32'(m_launch));
    check_val("start", 32'(col_start_o), 32'(m_launch ? m_lmask : 4'b0));
    if (m_launch) check_val("pc", 32'(col_pc_o), 32'(m_lpc));
    check_val("end",   32'(acc_end_o),   32'(e_end));
    check_val("busy",  32'(col_busy_o),  32'(m_busy));
    check_val("err",   32'(err_o),       32'(m_err));

    if (rst) begin
      m_busy    = '0;
      m_done    = '0;
      for (int c = 0; c < 4; c++) m_grp[c] = '0;
      m_err     = 1'b0;
      m_launch  = 1'b0;
      m_ok_from = cyc + 1;
    end else begin
      nb = m_busy & ~e_end;
      nd = (m_done | (done & m_busy)) & ~e_end;
      for (int c = 0; c < 4; c++) if (e_end[c]) m_grp[c] = '0;
      if ((done & ~m_busy) != 0) m_err = 1'b1;
      if (m_launch) begin
        nb = nb | m_lmask;
        for (int c = 0; c < 4; c++) if (m_lmask[c]) m_grp[c] = m_lmask;
      end
      m_launch = 1'b0;
      if (cyc >= m_ok_from && req != 0) begin
        if ((req & m_busy) == 0) begin
          m_launch  = 1'b1;
          m_lmask   = req;
          m_lpc     = pc;
          m_ok_from = cyc + 3;
        end else begin
          m_err = 1'b1;
        end
      end
      m_busy = nb;
      m_done = nd;
    end
    cyc++;
  endtask

  initial begin
    logic [3:0]  pend;
    logic [4:0]  ppc;
    logic [3:0]  dn;
    logic        rs;
    logic        ack_now;
    int unsigned acks;

    rst_i = 1'b1; acc_req_i = '0; pc_start_i = '0; col_done_i = '0;
    m_busy = '0; m_done = '0; m_err = 1'b0; m_launch = 1'b0;
    m_lmask = '0; m_lpc = '0; m_ok_from = 0; cyc = 0;
    for (int c = 0; c < 4; c++) m_grp[c] = '0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_val("rst_busy",  32'(col_busy_o), 32'(0));
    check_val("rst_start", 32'(col_start_o), 32'(0));
    check_val("rst_pc",    32'(col_pc_o), 32'(0));

    // single column launch and completion
    step(0, 4'b0001, 5, 0);
    step(0, 4'b0001, 5, 0);
    check_val("t1_start", 32'(col_start_o), 32'(4'b0001));
    check_val("t1_pc",    32'(col_pc_o), 32'(5));
    step(0, 0, 0, 0);
    check_val("t1_busy", 32'(col_busy_o), 32'(4'b0001));
    step(0, 0, 0, 4'b0001);
    check_val("t1_end", 32'(acc_end_o), 32'(4'b0001));
    step(0, 0, 0, 0);

    // two-column group ends only on its last done
    step(0, 4'b0110, 9, 0);
    step(0, 4'b0110, 9, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0010);
    check_val("t2_early", 32'(acc_end_o), 32'(0));
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b0100);
    check_val("t2_end", 32'(acc_end_o), 32'(4'b0110));
    step(0, 0, 0, 0);

    // disjoint groups coexist and finish together
    step(0, 4'b0011, 1, 0);
    step(0, 4'b0011, 1, 0);
    step(0, 0, 0, 0);
    step(0, 4'b1100, 2, 0);
    step(0, 4'b1100, 2, 0);
    check_val("t3_ack", 32'(acc_ack_o), 32'(1));
    step(0, 0, 0, 0);
    step(0, 0, 0, 4'b1111);
    check_val("t3_end", 32'(acc_end_o), 32'(4'b1111));
    step(0, 0, 0, 0);

    // overlapping request waits and flags an error
    step(0, 4'b0011, 3, 0);
    step(0, 4'b0011, 3, 0);
    step(0, 0, 0, 0);
    step(0, 4'b0010, 7, 0);
    step(0, 4'b0010, 7, 0);
    check_val("t4_noack", 32'(acc_ack_o), 32'(0));
    check_val("t4_err",   32'(err_o), 32'(1));
    step(0, 4'b0010, 7, 4'b0011);
    step(0, 4'b0010, 7, 0);
    check_val("t4_wait", 32'(acc_ack_o), 32'(0));
    step(0, 4'b0010, 7, 0);
    check_val("t4_ack", 32'(acc_ack_o), 32'(1));
    step(0, 0, 0, 0);

    // stray done on an idle column, then reset clears the error
    step(0, 0, 0, 4'b1000);
    check_val("t5_end", 32'(acc_end_o), 32'(0));
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("t5_err", 32'(err_o), 32'(0));

    // reset drops a running group; a held request acks once
    step(0, 4'b0001, 4, 0);
    step(0, 4'b0001, 4, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("t6_busy", 32'(col_busy_o), 32'(0));
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0001, 3, 0);
      if (acc_ack_o === 1'b1) acks++;
    end
    check_val("t6_acks", 32'(acks), 32'(1));
    step(0, 0, 0, 0);

    // randomized traffic against the model
    pend = '0;
    ppc  = '0;
    for (int i = 0; i < 4000; i++) begin
      if (pend == 0 && $urandom_range(0, 3) == 0) begin
        pend = 4'($urandom_range(1, 15));
        ppc  = 5'($urandom);
      end
      dn = '0;
      for (int c = 0; c < 4; c++) begin
        if (m_busy[c] && !m_done[c] && $urandom_range(0, 2) == 0) dn[c] = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) dn = dn | 4'($urandom);
      rs = ($urandom_range(0, 149) == 0);
      if (rs) dn = '0;
      ack_now = m_launch;
      step(rs, pend, ppc, dn);
      if (ack_now || rs) pend = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
